// File: rtl/apb_slave_ctrl.sv
// APB slave front end: turns APB transfers into a single-cycle internal
// request, waits for the internal ack (with optional timeout) and returns the
// APB response. Decode errors and abandoned transfers are handled locally.
//
// Handshake: req is a one-cycle pulse. we, addr, wdata and strb are valid
// with req and hold until the next req. The internal side answers with ack,
// high for one cycle, in the req cycle or in any later cycle. err and rdata
// are sampled only in the cycle where ack is high. ack is ignored when no
// request is outstanding.
module apb_slave_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int BASE_ADDR  = 0,
  parameter int SIZE_BYTES = 4096,
  parameter int TIMEOUT    = 15
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSELx,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                req,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] strb,
  input  logic                ack,
  input  logic                err,
  input  logic [DATA_W-1:0]   rdata,
  output logic                proto_err,
  output logic [1:0]          dbg_state
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [63:0]       WIN_LO     = 64'(BASE_ADDR);
  localparam logic [63:0]       WIN_HI     = 64'(BASE_ADDR) + 64'(SIZE_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_TO     = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                dec_err_q, wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NBYTES-1:0]   strb_q;
  logic                pready_q, pslverr_q, proto_q;
  logic [DATA_W-1:0]   prdata_q;

  logic                setup, dec_err_c, abandon;
  logic                resp_go, resp_err;
  logic [DATA_W-1:0]   resp_data;
  logic [DATA_W-1:0]   ack_data;

  // Address decode of the SETUP phase; a read carrying byte strobes is illegal.
  always_comb begin
    setup     = PSELx & ~PENABLE;
    dec_err_c = (64'(PADDR) < WIN_LO) || (64'(PADDR) >= WIN_HI) ||
                ((PADDR & ALIGN_MASK) != '0) || (!PWRITE && (PSTRB != '0));
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    ack_data  = (!wr_q && !err) ? rdata : '0;
  end

  // Next-state and request/response decisions; abandonment beats everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    resp_go   = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    abandon   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (!PSELx) begin
          abandon = 1'b1;
        end else if (dec_err_q) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else begin
          req = 1'b1;
          if (ack) begin
            resp_go   = 1'b1;
            resp_err  = err;
            resp_data = ack_data;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!PSELx || !PENABLE) begin
          abandon = 1'b1;
        end else if (ack) begin
          resp_go   = 1'b1;
          resp_err  = err;
          resp_data = ack_data;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT > 0) && (cnt_inc == CNT_TO)) begin
            resp_go  = 1'b1;
            resp_err = 1'b1;
          end
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (resp_go) state_d = S_RESP;
    if (abandon) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State, capture registers and registered APB response.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dec_err_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= resp_go;
      pslverr_q <= resp_err;
      prdata_q  <= resp_data;
      if (abandon) proto_q <= 1'b1;
      if (state_q == S_IDLE && setup) begin
        dec_err_q <= dec_err_c;
        // A rejected transfer never issues req, so the request fields keep
        // describing the last request actually sent.
        if (!dec_err_c) begin
          addr_q  <= PADDR - ADDR_W'(BASE_ADDR);
          wr_q    <= PWRITE;
          wdata_q <= PWDATA;
          strb_q  <= PSTRB;
        end
      end
    end
  end

  assign we        = req & wr_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign strb      = strb_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign PRDATA    = prdata_q;
  assign proto_err = proto_q;
  assign dbg_state = state_q;

endmodule

// File: doc/apb_slave_ctrl.md
APB_SLAVE_CTRL -- requirements
Module: apb_slave_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: PRDATA/PWDATA/rdata/wdata width; one of 8, 16, 32, 64.
REQ-002 Parameter ADDR_W, default 16: PADDR/addr width.
REQ-003 Parameter BASE_ADDR, default 0: first byte address decoded; DATA_W/8 aligned.
REQ-004 Parameter SIZE_BYTES, default 4096: decoded window length; multiple of DATA_W/8.
REQ-005 Parameter TIMEOUT, default 15: max wait cycles for ack; 0 disables timeout.
REQ-006 PCLK  in  1  sole clock; all state changes on rising edge.
REQ-007 PRESETn  in  1  reset, synchronous, active-low.
REQ-008 PSELx, PENABLE, PWRITE  in  1 each  APB select, enable, direction.
REQ-009 PADDR  in  ADDR_W  byte address; PWDATA  in  DATA_W  write data; PSTRB  in  DATA_W/8  byte strobes.
REQ-010 PREADY, PSLVERR  out  1 each  transfer complete; error response.
REQ-011 PRDATA  out  DATA_W  read data, registered.
REQ-012 req  out  1  single-cycle internal request pulse; we  out  1  write qualifier, valid with req.
REQ-013 addr  out  ADDR_W  offset PADDR-BASE_ADDR; wdata  out  DATA_W; strb  out  DATA_W/8; all held from req until next req.
REQ-014 ack  in  1  internal completion; err  in  1  internal error, sampled with ack; rdata  in  DATA_W, sampled with ack.
REQ-015 proto_err  out  1  sticky flag: master abandoned transfer.

Function
REQ-016 States IDLE, REQ, WAIT, RESP; state register only, next-state and outputs per state.
REQ-017 IDLE: PSELx & ~PENABLE -> REQ, capture PADDR/PWRITE/PWDATA/PSTRB; else stay.
REQ-018 Decode error at capture: PADDR outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES), PADDR low log2(DATA_W/8) bits nonzero, or read with PSTRB != 0.
REQ-019 REQ, decode error: req=0, next RESP with PSLVERR=1.
REQ-020 REQ, no decode error: req=1 and we=PWRITE for exactly this cycle; ack=1 this cycle -> RESP; else -> WAIT.
REQ-021 WAIT: req=0; ack=1 -> RESP; wait counter increments per WAIT cycle; counter == TIMEOUT (TIMEOUT>0) without ack -> RESP with PSLVERR=1.
REQ-022 Ack and timeout in same cycle: ack wins; err used as PSLVERR.
REQ-023 RESP: PREADY=1 for exactly one cycle; PSLVERR=registered error; PRDATA=captured rdata on successful read, 0 on write or error; -> IDLE.
REQ-024 PREADY=0, PSLVERR=0, PRDATA=0 in IDLE, REQ, WAIT; no output ever driven to Z or X.
REQ-025 Minimum latency: SETUP cycle, REQ cycle with PREADY=0, RESP cycle; zero-wait ack gives one wait state.
REQ-026 Back-to-back: new SETUP in cycle after RESP accepted from IDLE, no dead cycle.
REQ-027 PSELx=0 in REQ or WAIT: -> IDLE, counter cleared, proto_err set to 1, later ack ignored until next req.
REQ-028 PENABLE=0 with PSELx=1 in WAIT: same as REQ-027.
REQ-029 Write with PSTRB=0: legal, req issued, strb=0 passed through.
REQ-030 Wait counter width clog2(TIMEOUT+1), saturates, cleared on entry to REQ.

Reset
REQ-031 PRESETn=0 at a rising edge: state IDLE, counter 0; PREADY, PSLVERR, PRDATA, req, we, addr, wdata, strb, proto_err all 0 next cycle.
REQ-032 Reset mid-transfer (REQ/WAIT/RESP): transfer dropped, no PREADY issued, ack during reset ignored.
REQ-033 proto_err cleared only by reset.

Verification
REQ-034 Write 0x0000_00A5 to PADDR 0x10, ack in REQ cycle -> req one cycle, addr=0x10, we=1, PREADY at cycle 3, PSLVERR=0.
REQ-035 Read PADDR 0x20, ack after 3 WAIT cycles, rdata=0xDEAD_BEEF -> PREADY after 4 wait states, PRDATA=0xDEAD_BEEF, PRDATA=0 next cycle.
REQ-036 Read PADDR 0x1000 (SIZE_BYTES 4096) and write PADDR 0x02 -> no req, PREADY with PSLVERR=1 after one wait state.
REQ-037 TIMEOUT=15, ack never -> PREADY and PSLVERR=1 after 15 WAIT cycles; ack with err=1 on cycle 15 -> PSLVERR=1 via ack path.
REQ-038 PSELx dropped in WAIT -> IDLE, proto_err=1, late ack ignored; next transfer completes normally.
REQ-039 PRESETn=0 in WAIT -> all outputs 0, no PREADY; back-to-back writes after reset complete with no idle cycle between.
